// File: rtl/tk1_seq.sv
// -----------------------------------------------------------------------------
// tk1_seq -- byte-serial sequencer for the TK1 tweakey register (Romulus-N).
//
// Purpose:
//   Drives the per-cycle commands of the TK1 register file for one block of
//   ROUNDS round keys:
//   - an optional counter reset (RST);
//   - a counter/domain update (UPD);
//   - eight byte-chaining cycles per round (CHAIN), each emitting one TK1 byte
//     to the round-key consumer;
//   - a tweakey permutation at the end of each round (KSCH).
//
// Configuration macro:
//   TK1_SEQ_STALL_EN
//     defined   : kready backpressure is honoured in CHAIN.
//     undefined : kready is ignored (treated as 1). Every round takes exactly
//                 9 cycles.
//
// Parameters:
//   ROUNDS  round keys per block (40 for Skinny-128-384+).
//   RW      round counter width; 2**RW must exceed ROUNDS.
//
// Ports:
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   start           begin one block; only accepted in IDLE
//   new_msg         sampled with an accepted start; 1 = issue a TK1 counter
//                   reset first
//   domain_in[7:0]  domain byte, captured with an accepted start
//   kready          consumer ready for a key byte
//   tk_se           TK1 register enable
//   tk_rst          TK1 counter reset command
//   tk_chain        TK1 byte-rotate command
//   tk_ksch         TK1 tweakey permutation command
//   tk_correct_cnt  TK1 bytes are in natural order (meaningful in UPD)
//   tk_domain[7:0]  registered domain byte
//   kvalid          TK1 output byte is a valid round-key byte
//   round[RW-1:0]   current round index
//   byte_idx[2:0]   index of the key byte currently presented
//   busy            high in every state except IDLE
//   done            one-cycle pulse after the last permutation of a block
//
// Handshake: a key byte transfers in any cycle where kvalid && kready are both
// high. kvalid does not depend on kready. While kvalid is high and kready is
// low, TK1 holds (tk_se=0) and round/byte_idx stay frozen.
//
// Command outputs are decoded combinationally from the state registers and
// kready. There is no other path from an input to an output.
// -----------------------------------------------------------------------------
module tk1_seq #(
    parameter int ROUNDS = 40,
    parameter int RW     = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          new_msg,
    input  logic [7:0]    domain_in,
    input  logic          kready,
    output logic          tk_se,
    output logic          tk_rst,
    output logic          tk_chain,
    output logic          tk_ksch,
    output logic          tk_correct_cnt,
    output logic [7:0]    tk_domain,
    output logic          kvalid,
    output logic [RW-1:0] round,
    output logic [2:0]    byte_idx,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RST   = 3'd1,
        S_UPD   = 3'd2,
        S_CHAIN = 3'd3,
        S_KSCH  = 3'd4
    } state_t;

    localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

    state_t          state;
    logic            fresh;      // no permutation since the last counter reset
    logic [RW-1:0]   round_q;
    logic [2:0]      byte_q;
    logic [7:0]      domain_q;
    logic            done_q;
    logic            kready_eff;

`ifdef TK1_SEQ_STALL_EN
    assign kready_eff = kready;
`else
    // Backpressure is compiled out. The port stays so that both builds have
    // the same pin list.
    logic unused_kready;
    assign unused_kready = kready;
    assign kready_eff    = 1'b1;
`endif

    // -------------------------------------------------------------------------
    // State register and datapath counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            fresh    <= 1'b1;
            round_q  <= '0;
            byte_q   <= '0;
            domain_q <= 8'h00;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        domain_q <= domain_in;
                        round_q  <= '0;
                        byte_q   <= '0;
                        state    <= new_msg ? S_RST : S_UPD;
                    end
                end

                S_RST: begin
                    fresh <= 1'b1;
                    state <= S_UPD;
                end

                S_UPD: begin
                    // The block's permutations start right after this cycle,
                    // so the natural-order flag is consumed here.
                    fresh   <= 1'b0;
                    round_q <= '0;
                    byte_q  <= '0;
                    state   <= S_CHAIN;
                end

                S_CHAIN: begin
                    if (kready_eff) begin
                        // 3-bit counter: byte 7 wraps to 0 on its own.
                        byte_q <= byte_q + 3'd1;
                        if (byte_q == 3'd7) begin
                            state <= S_KSCH;
                        end
                    end
                end

                S_KSCH: begin
                    if (round_q == LAST_ROUND) begin
                        round_q <= '0;
                        done_q  <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        round_q <= round_q + RW'(1);
                        state   <= S_CHAIN;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Command decode. tk_rst, tk_chain and tk_ksch are one-hot per state and
    // are each paired with tk_se.
    // -------------------------------------------------------------------------
    always_comb begin
        tk_se          = 1'b0;
        tk_rst         = 1'b0;
        tk_chain       = 1'b0;
        tk_ksch        = 1'b0;
        tk_correct_cnt = 1'b0;
        kvalid         = 1'b0;
        case (state)
            S_RST: begin
                tk_se  = 1'b1;
                tk_rst = 1'b1;
            end
            S_UPD: begin
                tk_se          = 1'b1;
                tk_correct_cnt = fresh;
            end
            S_CHAIN: begin
                kvalid   = 1'b1;
                tk_se    = kready_eff;
                tk_chain = kready_eff;
            end
            S_KSCH: begin
                tk_se   = 1'b1;
                tk_ksch = 1'b1;
            end
            default: begin
                tk_se = 1'b0;
            end
        endcase
    end

    assign tk_domain = domain_q;
    assign round     = round_q;
    assign byte_idx  = byte_q;
    assign busy      = (state != S_IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_tk1_seq.sv
module tb_tk1_seq;

    localparam int ROUNDS = 40;
    localparam int RW     = 6;
`ifdef TK1_SEQ_STALL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          new_msg = 1'b0;
    logic [7:0]    domain_in = 8'h00;
    logic          kready = 1'b1;
    logic          tk_se, tk_rst, tk_chain, tk_ksch, tk_correct_cnt;
    logic [7:0]    tk_domain;
    logic          kvalid;
    logic [RW-1:0] round;
    logic [2:0]    byte_idx;
    logic          busy, done;

    always #5 clk = ~clk;

    tk1_seq #(.ROUNDS(ROUNDS), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .new_msg(new_msg),
        .domain_in(domain_in), .kready(kready), .tk_se(tk_se), .tk_rst(tk_rst),
        .tk_chain(tk_chain), .tk_ksch(tk_ksch), .tk_correct_cnt(tk_correct_cnt),
        .tk_domain(tk_domain), .kvalid(kvalid), .round(round),
        .byte_idx(byte_idx), .busy(busy), .done(done)
    );

    // ---------------- event counters (sampled on the falling edge) ----------------
    int n_chain = 0;
    int n_ksch = 0;
    int n_acc = 0;
    int n_overlap = 0;

    always @(negedge clk) begin
        if (tk_chain) n_chain++;
        if (tk_ksch) n_ksch++;
        if (kvalid && (kready || !STALL)) n_acc++;
        if ((int'(tk_rst) + int'(tk_chain) + int'(tk_ksch)) > 1 ||
            ((tk_rst || tk_chain || tk_ksch) && !tk_se))
            n_overlap++;
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int t_acc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic accept(input logic nm, input logic [7:0] dom);
        start     = 1'b1;
        new_msg   = nm;
        domain_in = dom;
        tick();
        start = 1'b0;
        t_acc = cyc;
    endtask

    task automatic wait_done(input string tag, output int lat);
        int n;
        n = 0;
        while (!done && n < 2000) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        lat = cyc - t_acc;
    endtask

    task automatic wait_pos(input string tag, input int r, input int b);
        int n;
        n = 0;
        while (!(kvalid && int'(round) == r && int'(byte_idx) == b) && n < 2000) begin
            tick();
            n++;
        end
        check({tag, "_pos_reached"}, 32'(kvalid && int'(round) == r && int'(byte_idx) == b), 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int lat;
        int c0, k0, a0;

        // Reset values
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_tk_se", 32'(tk_se), 0);
        check("rst_kvalid", 32'(kvalid), 0);
        check("rst_done", 32'(done), 0);
        check("rst_round", 32'(round), 0);
        check("rst_byte_idx", 32'(byte_idx), 0);
        check("rst_tk_domain", 32'(tk_domain), 0);
        check("rst_correct_cnt", 32'(tk_correct_cnt), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Block 1: new_msg=1, domain 0x5A -> RST, UPD(fresh), 362 cycles
        c0 = n_chain; k0 = n_ksch; a0 = n_acc;
        accept(1'b1, 8'h5A);
        check("b1_rst_tk_se", 32'(tk_se), 1);
        check("b1_rst_tk_rst", 32'(tk_rst), 1);
        check("b1_rst_busy", 32'(busy), 1);
        check("b1_tk_domain", 32'(tk_domain), 32'h5A);
        tick();
        check("b1_upd_tk_se", 32'(tk_se), 1);
        check("b1_upd_tk_rst", 32'(tk_rst), 0);
        check("b1_upd_correct_cnt", 32'(tk_correct_cnt), 1);
        check("b1_upd_round", 32'(round), 0);
        tick();
        check("b1_chain_kvalid", 32'(kvalid), 1);
        check("b1_chain_tk_chain", 32'(tk_chain), 1);
        check("b1_chain_byte_idx", 32'(byte_idx), 0);
        wait_done("b1", lat);
        check("b1_latency", 32'(lat), 362);
        check("b1_busy_at_done", 32'(busy), 0);
        check("b1_chain_pulses", 32'(n_chain - c0), 320);
        check("b1_ksch_pulses", 32'(n_ksch - k0), 40);
        check("b1_accepted", 32'(n_acc - a0), 320);

        // Block 2: start in the same cycle as done, new_msg=0 -> no RST, 361 cycles
        c0 = n_chain; k0 = n_ksch; a0 = n_acc;
        accept(1'b0, 8'hA5);
        check("b2_upd_tk_se", 32'(tk_se), 1);
        check("b2_upd_tk_rst", 32'(tk_rst), 0);
        check("b2_upd_correct_cnt", 32'(tk_correct_cnt), 0);
        check("b2_tk_domain", 32'(tk_domain), 32'hA5);
        check("b2_done_cleared", 32'(done), 0);
        wait_done("b2", lat);
        check("b2_latency", 32'(lat), 361);
        check("b2_chain_pulses", 32'(n_chain - c0), 320);
        check("b2_ksch_pulses", 32'(n_ksch - k0), 40);
        tick();

        // Block 3: consumer stall of 5 cycles at round 3, byte 4
        c0 = n_chain; k0 = n_ksch; a0 = n_acc;
        accept(1'b0, 8'h11);
        wait_pos("b3", 3, 4);
        kready = 1'b0;
        #1;
        check("b3_stall_tk_se", 32'(tk_se), 32'(!STALL));
        check("b3_stall_kvalid", 32'(kvalid), 1);
        repeat (5) tick();
`ifdef TK1_SEQ_STALL_EN
        check("b3_stall_round", 32'(round), 3);
        check("b3_stall_byte_idx", 32'(byte_idx), 4);
        check("b3_stall_chain", 32'(tk_chain), 0);
`endif
        kready = 1'b1;
        wait_done("b3", lat);
        check("b3_latency", 32'(lat), STALL ? 366 : 361);
        check("b3_chain_pulses", 32'(n_chain - c0), 320);
        check("b3_accepted", 32'(n_acc - a0), 320);
        tick();

        // Block 4: start pulsed while busy at round 10 is ignored
        accept(1'b0, 8'h22);
        wait_pos("b4", 10, 0);
        start     = 1'b1;
        new_msg   = 1'b1;
        domain_in = 8'hC3;
        tick();
        start = 1'b0;
        check("b4_domain_kept", 32'(tk_domain), 32'h22);
        check("b4_busy", 32'(busy), 1);
        check("b4_no_rst", 32'(tk_rst), 0);
        wait_done("b4", lat);
        check("b4_latency", 32'(lat), 361);
        tick();
        check("b4_single_done", 32'(done), 0);
        check("b4_idle_after", 32'(busy), 0);

        // Block 5: asynchronous reset at round 20, then a clean block
        accept(1'b1, 8'h44);
        wait_pos("b5", 20, 3);
        rst_n = 1'b0;
        #1;
        check("b5_rst_busy", 32'(busy), 0);
        check("b5_rst_tk_se", 32'(tk_se), 0);
        check("b5_rst_kvalid", 32'(kvalid), 0);
        check("b5_rst_tk_chain", 32'(tk_chain), 0);
        check("b5_rst_round", 32'(round), 0);
        check("b5_rst_byte_idx", 32'(byte_idx), 0);
        check("b5_rst_tk_domain", 32'(tk_domain), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        accept(1'b1, 8'h3C);
        check("b6_rst_tk_rst", 32'(tk_rst), 1);
        tick();
        check("b6_upd_correct_cnt", 32'(tk_correct_cnt), 1);
        check("b6_tk_domain", 32'(tk_domain), 32'h3C);
        wait_done("b6", lat);
        check("b6_latency", 32'(lat), 362);
        tick();

        check("cmd_overlap", 32'(n_overlap), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
